pdh_cmd_sched: RTL and testbench

PDH_CMD_SCHED -- requirements
Module: pdh_cmd_sched

---
 rtl/pdh_cmd_sched_if.sv | 26 ++
 rtl/pdh_cmd_sched.sv | 176 +++++++++++++++++
 tb/tb_pdh_cmd_sched.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pdh_cmd_sched_if.sv
// Command/response handshake bundle between a requester and pdh_cmd_sched.
// Signal names keep the scheduler-side _i/_o suffixes so both ends read the same.
interface pdh_cmd_sched_if #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned CALLBACK_WIDTH = 8
) ();
    logic                      cmd_valid_i;
    logic                      cmd_ready_o;
    logic [1:0]                cmd_op_i;
    logic [7:0]                cmd_id_i;
    logic [DATA_WIDTH-1:0]     cmd_data_i;
    logic                      rsp_valid_o;
    logic                      rsp_ready_i;
    logic [CALLBACK_WIDTH-1:0] rsp_data_o;
    logic                      rsp_err_o;

    modport master (
        output cmd_valid_i, cmd_op_i, cmd_id_i, cmd_data_i, rsp_ready_i,
        input  cmd_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o
    );

    modport slave (
        input  cmd_valid_i, cmd_op_i, cmd_id_i, cmd_data_i, rsp_ready_i,
        output cmd_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o
    );
endinterface

// File: rtl/pdh_cmd_sched.sv
// Sequences SET/CLEAR/READ/NOP commands onto N_SLAVES command slaves: one-cycle
// strobe, fixed settle wait, callback sample and check, then a held response.
module pdh_cmd_sched #(
    parameter int unsigned N_SLAVES       = 4,
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned CALLBACK_WIDTH = 8,
    parameter int unsigned SETTLE_CYCLES  = 5
) (
    input  logic                               clk,
    input  logic                               rst_ni,
    pdh_cmd_sched_if.slave                     bus,
    output logic [N_SLAVES-1:0]                en_o,
    output logic [N_SLAVES-1:0]                clr_o,
    output logic [DATA_WIDTH-1:0]              data_o,
    input  logic [N_SLAVES*CALLBACK_WIDTH-1:0] cb_i,
    output logic                               busy_o
);
    localparam int unsigned ID_W  = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
    localparam int unsigned CNT_W = 8;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_SET   = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;
    localparam logic [1:0] OP_READ  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STROBE,
        ST_WAIT,
        ST_RESP
    } state_e;

    state_e                    state_q, state_d;
    logic [1:0]                op_q, op_d;
    logic [ID_W-1:0]           id_q, id_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [N_SLAVES-1:0]       en_q, en_d;
    logic [N_SLAVES-1:0]       clr_q, clr_d;
    logic [DATA_WIDTH-1:0]     data_q, data_d;
    logic                      rsp_valid_q, rsp_valid_d;
    logic [CALLBACK_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                      rsp_err_q, rsp_err_d;
    logic                      busy_q, busy_d;
    logic                      ready_q, ready_d;

    logic [CALLBACK_WIDTH-1:0] cb_sel_c;
    logic                      id_ok_c;
    logic                      accept_c;

    // Callback slice of the addressed slave.
    always_comb begin
        cb_sel_c = '0;
        for (int i = 0; i < int'(N_SLAVES); i++) begin
            if (ID_W'(i) == id_q) begin
                cb_sel_c = cb_i[i*CALLBACK_WIDTH +: CALLBACK_WIDTH];
            end
        end
    end

    assign id_ok_c  = 32'(bus.cmd_id_i) < N_SLAVES;
    assign accept_c = bus.cmd_valid_i & ready_q;

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        id_d        = id_q;
        cnt_d       = cnt_q;
        en_d        = '0;
        clr_d       = '0;
        data_d      = data_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    op_d = bus.cmd_op_i;
                    id_d = ID_W'(bus.cmd_id_i);
                    if (!id_ok_c || bus.cmd_op_i == OP_NOP) begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = '0;
                        rsp_err_d   = !id_ok_c;
                    end else begin
                        state_d = ST_STROBE;
                        if (bus.cmd_op_i == OP_SET) begin
                            en_d   = N_SLAVES'(1) << ID_W'(bus.cmd_id_i);
                            data_d = bus.cmd_data_i;
                        end else if (bus.cmd_op_i == OP_CLEAR) begin
                            clr_d  = N_SLAVES'(1) << ID_W'(bus.cmd_id_i);
                            data_d = '0;
                        end
                    end
                end
            end
            ST_STROBE: begin
                // READ rides through STROBE with no strobe and samples right away.
                if (op_q == OP_READ) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = cb_sel_c;
                    rsp_err_d   = 1'b0;
                end else begin
                    state_d = ST_WAIT;
                    cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = cb_sel_c;
                    if (op_q == OP_SET) begin
                        rsp_err_d = cb_sel_c != CALLBACK_WIDTH'(data_q);
                    end else begin
                        rsp_err_d = cb_sel_c != '0;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready_i) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        ready_d = state_d == ST_IDLE;
        busy_d  = state_d != ST_IDLE;
    end

    // ready_q resets high so an accept is possible on the first edge after release.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_NOP;
            id_q        <= '0;
            cnt_q       <= '0;
            en_q        <= '0;
            clr_q       <= '0;
            data_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            id_q        <= id_d;
            cnt_q       <= cnt_d;
            en_q        <= en_d;
            clr_q       <= clr_d;
            data_q      <= data_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            busy_q      <= busy_d;
            ready_q     <= ready_d;
        end
    end

    assign bus.cmd_ready_o = ready_q & rst_ni;
    assign bus.rsp_valid_o = rsp_valid_q;
    assign bus.rsp_data_o  = rsp_data_q;
    assign bus.rsp_err_o   = rsp_err_q;
    assign en_o            = en_q;
    assign clr_o           = clr_q;
    assign data_o          = data_q;
    assign busy_o          = busy_q;
endmodule

// File: tb/tb_pdh_cmd_sched.sv
// Directed bench for pdh_cmd_sched: transaction-level model with per-cycle compare,
// an echoing slave model on cb_i, and hand-computed checks for the key scenarios.
module tb_pdh_cmd_sched;
    localparam int NS = 4;
    localparam int S  = 5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  en_o, clr_o;
    logic [7:0]  data_o;
    logic [31:0] cb;
    logic        busy_o;

    pdh_cmd_sched_if #(.DATA_WIDTH(8), .CALLBACK_WIDTH(8)) bus ();

    pdh_cmd_sched #(
        .N_SLAVES(NS), .DATA_WIDTH(8), .CALLBACK_WIDTH(8), .SETTLE_CYCLES(S)
    ) dut (
        .clk(clk), .rst_ni(rst_n), .bus(bus), .en_o(en_o), .clr_o(clr_o),
        .data_o(data_o), .cb_i(cb), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    logic cmp_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Slave model: applies a strobe to its callback 4 cycles later unless stuck.
    logic       stuck [NS];
    logic [7:0] cb_val [NS];
    logic [7:0] pend_val [NS];
    int         pend_cnt [NS];

    always_comb begin
        cb = '0;
        for (int i = 0; i < NS; i++) cb[i*8 +: 8] = cb_val[i];
    end

    always @(posedge clk) begin
        for (int i = 0; i < NS; i++) begin
            if (!stuck[i] && (en_o[i] || clr_o[i])) begin
                pend_val[i] <= en_o[i] ? data_o : 8'h00;
                pend_cnt[i] <= 4;
            end else if (pend_cnt[i] != 0) begin
                pend_cnt[i] <= pend_cnt[i] - 1;
                if (pend_cnt[i] == 1) cb_val[i] <= pend_val[i];
            end
        end
    end

    // Transaction model: m_t counts cycles since accept (1 = first cycle after it).
    logic       m_busy = 1'b0;
    int         m_t = 0;
    int         m_lat = 0;
    logic [1:0] m_op = 2'b00;
    logic [7:0] m_id = 8'h00;
    logic [7:0] m_data = 8'h00;
    logic       m_idok = 1'b0;
    logic [7:0] m_dout = 8'h00;
    logic [7:0] m_rd = 8'h00;
    logic       m_er = 1'b0;
    logic [7:0] m_slv [NS];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 1'b0;
            m_t    = 0;
            m_dout = 8'h00;
        end else if (m_busy) begin
            if (m_t == 1 && m_idok && (m_op == 2'b01 || m_op == 2'b10) && !stuck[m_id[1:0]])
                m_slv[m_id[1:0]] = (m_op == 2'b01) ? m_data : 8'h00;
            if (m_t >= m_lat && bus.rsp_ready_i) m_busy = 1'b0;
            else if (m_t < 1000) m_t++;
        end else if (bus.cmd_valid_i) begin
            m_busy = 1'b1;
            m_t    = 1;
            m_op   = bus.cmd_op_i;
            m_id   = bus.cmd_id_i;
            m_data = bus.cmd_data_i;
            m_idok = bus.cmd_id_i < 8'(NS);
            if (!m_idok) begin
                m_lat = 1; m_rd = 8'h00; m_er = 1'b1;
            end else begin
                case (m_op)
                    2'b00: begin m_lat = 1; m_rd = 8'h00; m_er = 1'b0; end
                    2'b11: begin m_lat = 2; m_rd = m_slv[m_id[1:0]]; m_er = 1'b0; end
                    2'b01: begin
                        m_lat  = 2 + S;
                        m_rd   = stuck[m_id[1:0]] ? m_slv[m_id[1:0]] : m_data;
                        m_er   = m_rd != m_data;
                        m_dout = m_data;
                    end
                    default: begin
                        m_lat  = 2 + S;
                        m_rd   = stuck[m_id[1:0]] ? m_slv[m_id[1:0]] : 8'h00;
                        m_er   = m_rd != 8'h00;
                        m_dout = 8'h00;
                    end
                endcase
            end
        end
    end

    // Per-cycle compare of every output against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            logic       strobe_cyc;
            logic [3:0] oh;
            logic       rv;
            strobe_cyc = m_busy && m_t == 1 && m_idok;
            oh = 4'b0001 << m_id[1:0];
            rv = m_busy && m_t >= m_lat;
            chk("cmd_ready", 32'(bus.cmd_ready_o), 32'(rst_n && !m_busy));
            chk("busy", 32'(busy_o), 32'(m_busy));
            chk("en", 32'(en_o), 32'((strobe_cyc && m_op == 2'b01) ? oh : 4'b0));
            chk("clr", 32'(clr_o), 32'((strobe_cyc && m_op == 2'b10) ? oh : 4'b0));
            chk("data_o", 32'(data_o), 32'(m_dout));
            chk("rsp_valid", 32'(bus.rsp_valid_o), 32'(rv));
            if (rv) begin
                chk("rsp_data", 32'(bus.rsp_data_o), 32'(m_rd));
                chk("rsp_err", 32'(bus.rsp_err_o), 32'(m_er));
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [7:0] id, input logic [7:0] d,
                         output int lat, output logic [7:0] rd, output logic er,
                         output logic [3:0] en_seen, output logic [3:0] clr_seen,
                         output int nstrb);
        lat = 0; rd = 8'h00; er = 1'b0; en_seen = 4'b0; clr_seen = 4'b0; nstrb = 0;
        @(posedge clk); #1;
        bus.cmd_valid_i = 1'b1; bus.cmd_op_i = op; bus.cmd_id_i = id; bus.cmd_data_i = d;
        @(posedge clk); #1;
        bus.cmd_valid_i = 1'b0;
        for (int n = 1; n <= 300; n++) begin
            @(negedge clk);
            en_seen  = en_seen | en_o;
            clr_seen = clr_seen | clr_o;
            if ((en_o | clr_o) != 4'b0) nstrb++;
            if (bus.rsp_valid_o) begin
                lat = n; rd = bus.rsp_data_o; er = bus.rsp_err_o;
                break;
            end
        end
        if (lat == 0) chk("rsp_timeout", 32'(0), 32'(1));
    endtask

    int         lat, nstrb, cnt;
    logic [7:0] rd;
    logic       er;
    logic [3:0] es, cs;

    task automatic check_quiet(input string tag);
        chk({tag, "_en"}, 32'(en_o), 32'(0));
        chk({tag, "_clr"}, 32'(clr_o), 32'(0));
        chk({tag, "_busy"}, 32'(busy_o), 32'(0));
        chk({tag, "_ready"}, 32'(bus.cmd_ready_o), 32'(0));
        chk({tag, "_rvalid"}, 32'(bus.rsp_valid_o), 32'(0));
        chk({tag, "_data"}, 32'(data_o), 32'(0));
    endtask

    task automatic release_and_watch(input string tag);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        cnt = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (bus.rsp_valid_o) cnt++;
        end
        chk({tag, "_no_rsp"}, 32'(cnt), 32'(0));
    endtask

    initial begin
        for (int i = 0; i < NS; i++) begin
            stuck[i] = 1'b0; cb_val[i] = 8'h00; pend_val[i] = 8'h00;
            pend_cnt[i] = 0; m_slv[i] = 8'h00;
        end
        rst_n = 1'b0;
        bus.cmd_valid_i = 1'b0; bus.cmd_op_i = 2'b00; bus.cmd_id_i = 8'h00;
        bus.cmd_data_i = 8'h00; bus.rsp_ready_i = 1'b1;
        #1 cmp_en = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_quiet("reset");
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", 32'(bus.cmd_ready_o), 32'(1));

        // SET id2 0xA5 with echoing slave.
        issue(2'b01, 8'd2, 8'hA5, lat, rd, er, es, cs, nstrb);
        chk("set2_lat", 32'(lat), 32'(7));
        chk("set2_data", 32'(rd), 32'(8'hA5));
        chk("set2_err", 32'(er), 32'(0));
        chk("set2_en", 32'(es), 32'(4'b0100));
        chk("set2_nstrb", 32'(nstrb), 32'(1));

        // SET id1 0x3C with callback stuck at zero.
        @(posedge clk); #1 stuck[1] = 1'b1;
        issue(2'b01, 8'd1, 8'h3C, lat, rd, er, es, cs, nstrb);
        chk("set1_stuck_data", 32'(rd), 32'(0));
        chk("set1_stuck_err", 32'(er), 32'(1));

        // SET id0 then CLEAR id0.
        issue(2'b01, 8'd0, 8'h11, lat, rd, er, es, cs, nstrb);
        chk("set0_err", 32'(er), 32'(0));
        issue(2'b10, 8'd0, 8'h99, lat, rd, er, es, cs, nstrb);
        chk("clr0_clr", 32'(cs), 32'(4'b0001));
        chk("clr0_en", 32'(es), 32'(0));
        chk("clr0_nstrb", 32'(nstrb), 32'(1));
        chk("clr0_data", 32'(rd), 32'(0));
        chk("clr0_err", 32'(er), 32'(0));
        chk("clr0_lat", 32'(lat), 32'(7));

        // READ of a valid slave and of an out-of-range id.
        issue(2'b11, 8'd2, 8'h00, lat, rd, er, es, cs, nstrb);
        chk("rd2_lat", 32'(lat), 32'(2));
        chk("rd2_data", 32'(rd), 32'(8'hA5));
        chk("rd2_nstrb", 32'(nstrb), 32'(0));
        issue(2'b11, 8'd7, 8'h00, lat, rd, er, es, cs, nstrb);
        chk("rd7_lat", 32'(lat), 32'(1));
        chk("rd7_err", 32'(er), 32'(1));
        chk("rd7_data", 32'(rd), 32'(0));
        chk("rd7_nstrb", 32'(nstrb), 32'(0));

        // NOP.
        issue(2'b00, 8'd0, 8'h00, lat, rd, er, es, cs, nstrb);
        chk("nop_lat", 32'(lat), 32'(1));
        chk("nop_err", 32'(er), 32'(0));

        // Backpressure on response while a new command is held.
        @(posedge clk); #1 bus.rsp_ready_i = 1'b0;
        issue(2'b00, 8'd1, 8'h00, lat, rd, er, es, cs, nstrb);
        #1;
        bus.cmd_valid_i = 1'b1; bus.cmd_op_i = 2'b01; bus.cmd_id_i = 8'd3; bus.cmd_data_i = 8'h77;
        cnt = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (bus.rsp_valid_o && !bus.cmd_ready_o && en_o == 4'b0 && !bus.rsp_err_o) cnt++;
        end
        chk("bp_hold_cycles", 32'(cnt), 32'(10));
        @(posedge clk); #1 bus.rsp_ready_i = 1'b1;
        @(posedge clk);
        cnt = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (en_o != 4'b0) begin cnt = n; break; end
        end
        chk("bp_strobe_after", 32'(cnt), 32'(2));
        chk("bp_strobe_en", 32'(en_o), 32'(4'b1000));
        @(posedge clk); #1 bus.cmd_valid_i = 1'b0;
        cnt = 0;
        for (int n = 0; n < 50 && busy_o; n++) @(negedge clk);
        chk("bp_drain", 32'(busy_o), 32'(0));

        // Reset asserted during STROBE.
        @(posedge clk); #1;
        bus.cmd_valid_i = 1'b1; bus.cmd_op_i = 2'b01; bus.cmd_id_i = 8'd3; bus.cmd_data_i = 8'h55;
        @(posedge clk); #1 bus.cmd_valid_i = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_quiet("rst_strobe");
        release_and_watch("rst_strobe");

        // Reset asserted during WAIT.
        @(posedge clk); #1;
        bus.cmd_valid_i = 1'b1; bus.cmd_op_i = 2'b01; bus.cmd_id_i = 8'd3; bus.cmd_data_i = 8'h66;
        @(posedge clk); #1 bus.cmd_valid_i = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_quiet("rst_wait");
        release_and_watch("rst_wait");

        // Normal operation after resets.
        issue(2'b01, 8'd3, 8'h5A, lat, rd, er, es, cs, nstrb);
        chk("post_rst_lat", 32'(lat), 32'(7));
        chk("post_rst_data", 32'(rd), 32'(8'h5A));
        chk("post_rst_err", 32'(er), 32'(0));
        issue(2'b11, 8'd3, 8'h00, lat, rd, er, es, cs, nstrb);
        chk("post_rst_read", 32'(rd), 32'(8'h5A));

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
